ssd_mux_driver: RTL and testbench

Time-multiplexed four-digit seven-segment display driver that sits directly downstream of the ALU. It accepts the ALU's 16-bit result and overflow flag through a valid/ready handshake and latches them into a display register. It then scans the digits continuously, driving common-anode, active-low anode and segment lines. An optional compile-time feature replaces the default hex display with a sequential signed-decimal conversion.

---
 rtl/ssd_pkg.sv | 25 ++
 rtl/ssd_mux_driver_seg7_decode.sv | 35 +++
 rtl/ssd_mux_driver.sv | 186 ++++++++++++++++++
 tb/tb_ssd_mux_driver.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display driver: symbol codes,
// digit count, conversion FSM states and the double-dabble nibble adjust.
package ssd_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [4:0] sym_t;

    localparam sym_t SYM_DASH  = 5'd16;
    localparam sym_t SYM_MINUS = 5'd17;
    localparam sym_t SYM_BLANK = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } ssd_state_e;

    // Double-dabble correction: a BCD nibble of 5 or more gets +3
    // so that the following left shift carries into the next digit.
    function automatic logic [3:0] dabble_adj(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

endpackage

// File: rtl/ssd_mux_driver_seg7_decode.sv
// seg7_decode: combinational symbol-to-segment decoder.
// Ports: sym_i (5-bit symbol code), seg_o ({g,f,e,d,c,b,a}, active-low).
module seg7_decode
    import ssd_pkg::*;
(
    input  logic [4:0] sym_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        case (sym_i)
            5'd0:      seg_o = 7'h40;
            5'd1:      seg_o = 7'h79;
            5'd2:      seg_o = 7'h24;
            5'd3:      seg_o = 7'h30;
            5'd4:      seg_o = 7'h19;
            5'd5:      seg_o = 7'h12;
            5'd6:      seg_o = 7'h02;
            5'd7:      seg_o = 7'h78;
            5'd8:      seg_o = 7'h00;
            5'd9:      seg_o = 7'h10;
            5'd10:     seg_o = 7'h08;
            5'd11:     seg_o = 7'h03;
            5'd12:     seg_o = 7'h46;
            5'd13:     seg_o = 7'h21;
            5'd14:     seg_o = 7'h06;
            5'd15:     seg_o = 7'h0E;
            SYM_DASH:  seg_o = 7'h3F;
            SYM_MINUS: seg_o = 7'h3F;
            default:   seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/ssd_mux_driver.sv
// ssd_mux_driver: four-digit multiplexed seven-segment driver fed by a
// valid/ready handshake. Ports: clk, rst_n (async, active-low), in_valid,
// in_ready, in_value[15:0], in_overflow, an[3:0], seg[6:0], dp (active-low).
// Define SSD_BCD_EN for signed-decimal display via a sequential converter;
// otherwise the value is shown in hex and in_ready is tied high.
module ssd_mux_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    input  logic        in_overflow,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;

    logic [NUM_DIGITS-1:0][4:0] sym_q, sym_d;
    logic                       ovf_q, ovf_d;

    logic [3:0] an_q;
    logic [6:0] seg_q;
    logic       dp_q;
    logic [6:0] seg_w;

    // Scan: each digit stays lit for REFRESH_DIV clocks, independent of input.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    seg7_decode u_dec (
        .sym_i (sym_q[idx_q]),
        .seg_o (seg_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
            an_q  <= 4'b1111;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
            sym_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= seg_w;
            dp_q  <= ~(ovf_q && (idx_q == 2'd0));
            sym_q <= sym_d;
            ovf_q <= ovf_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

`ifdef SSD_BCD_EN

    ssd_state_e  state_q, state_d;
    logic [15:0] sh_q, sh_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  it_q, it_d;
    logic        neg_q, neg_d;
    logic        dash_q, dash_d;
    logic        povf_q, povf_d;

    logic [15:0] mag;
    logic [15:0] adj;
    logic        out_rng;

    // Range is decided at the transfer edge; 0x8000 negates to itself
    // and therefore lands in the out-of-range branch.
    assign mag     = in_value[15] ? (~in_value + 16'd1) : in_value;
    assign out_rng = in_value[15] ? (mag > 16'd999) : (mag > 16'd9999);

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            adj[4*i +: 4] = dabble_adj(bcd_q[4*i +: 4]);
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        it_d    = it_q;
        neg_d   = neg_q;
        dash_d  = dash_q;
        povf_d  = povf_q;
        sym_d   = sym_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sh_d    = mag;
                    bcd_d   = '0;
                    it_d    = 4'd0;
                    neg_d   = in_value[15];
                    dash_d  = in_overflow | out_rng;
                    povf_d  = in_overflow;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                {bcd_d, sh_d} = {adj[14:0], sh_q, 1'b0};
                it_d = it_q + 4'd1;
                if (it_q == 4'd15) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (dash_q) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        sym_d[i] = SYM_DASH;
                    end
                end else begin
                    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
                        sym_d[i] = {1'b0, bcd_q[4*i +: 4]};
                    end
                    sym_d[3] = neg_q ? SYM_MINUS : {1'b0, bcd_q[15:12]};
                end
                ovf_d   = povf_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            it_q    <= '0;
            neg_q   <= 1'b0;
            dash_q  <= 1'b0;
            povf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            it_q    <= it_d;
            neg_q   <= neg_d;
            dash_q  <= dash_d;
            povf_q  <= povf_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);

`else

    assign in_ready = 1'b1;

    always_comb begin
        sym_d = sym_q;
        ovf_d = ovf_q;
        if (in_valid) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                sym_d[i] = {1'b0, in_value[4*i +: 4]};
            end
            ovf_d = in_overflow;
        end
    end

`endif

endmodule

// File: tb/tb_ssd_mux_driver.sv
// Directed bench for ssd_mux_driver with REFRESH_DIV=4; expectations are
// hand-computed and switch with SSD_BCD_EN.
module tb_ssd_mux_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_value = '0;
    logic        in_overflow = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ssd_mux_driver #(.REFRESH_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .in_overflow (in_overflow),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("ready_tmo", {15'b0, in_ready}, 16'd1);
    endtask

    task automatic xfer(input logic [15:0] v, input logic o);
        wait_ready();
        in_value    = v;
        in_overflow = o;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid    = 1'b0;
        @(negedge clk);
        wait_ready();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_digits(input string tag,
                                input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0,
                                input logic o);
        logic [6:0] ex [4];
        ex[0] = s0; ex[1] = s1; ex[2] = s2; ex[3] = s3;
        for (int d = 0; d < 4; d++) begin
            logic [3:0] tgt;
            int n;
            tgt = ~(4'b0001 << d);
            n = 0;
            while (an !== tgt && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) chk({tag, "_an_tmo"}, {12'b0, an}, {12'b0, tgt});
            chk($sformatf("%s_seg%0d", tag, d), {9'b0, seg}, {9'b0, ex[d]});
            chk($sformatf("%s_dp%0d", tag, d), {15'b0, dp},
                {15'b0, ~(o && d == 0)});
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_an",  {12'b0, an},  16'h000F);
        chk("rst_seg", {9'b0, seg},  16'h007F);
        chk("rst_dp",  {15'b0, dp},  16'h0001);
        chk("rst_rdy", {15'b0, in_ready}, 16'h0001);

        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("scan_an%0d", k), {12'b0, an},
                {12'b0, ~(4'b0001 << (k / 4))});
            chk($sformatf("scan_seg%0d", k), {9'b0, seg}, 16'h0040);
        end

`ifdef SSD_BCD_EN
        xfer(16'h00E5, 1'b0);
        check_digits("dec229", 7'h40, 7'h24, 7'h24, 7'h10, 1'b0);

        xfer(16'h0031, 1'b1);
        check_digits("ovf", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);

        begin
            int lows = 0;
            wait_ready();
            in_value = 16'd14; in_overflow = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            while (in_ready === 1'b0 && lows < 40) begin
                lows++;
                if (lows == 5) begin
                    in_value = 16'd99; in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
            end
            in_valid = 1'b0;
            chk("conv_lat", lows[15:0], 16'd17);
            @(negedge clk);
            @(negedge clk);
            check_digits("dec14", 7'h40, 7'h40, 7'h79, 7'h19, 1'b0);
        end

        xfer(16'hFFFB, 1'b0);
        check_digits("neg5", 7'h3F, 7'h40, 7'h40, 7'h12, 1'b0);
        xfer(16'hFC17, 1'b0);
        check_digits("neg1001", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0);
        xfer(16'hFC19, 1'b0);
        check_digits("neg999", 7'h3F, 7'h10, 7'h10, 7'h10, 1'b0);
        xfer(16'd9999, 1'b0);
        check_digits("pos9999", 7'h10, 7'h10, 7'h10, 7'h10, 1'b0);
        xfer(16'd10000, 1'b0);
        check_digits("pos10000", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0);
        xfer(16'h8000, 1'b0);
        check_digits("min", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0);
`else
        xfer(16'h00E5, 1'b0);
        check_digits("hexE5", 7'h40, 7'h40, 7'h06, 7'h12, 1'b0);

        xfer(16'h0031, 1'b1);
        check_digits("ovf", 7'h40, 7'h40, 7'h30, 7'h79, 1'b1);

        // Back-to-back transfers; the second one must win.
        in_overflow = 1'b0;
        in_value = 16'h1234; in_valid = 1'b1;
        @(negedge clk);
        in_value = 16'h5678;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_digits("b2b", 7'h12, 7'h02, 7'h78, 7'h00, 1'b0);

        xfer(16'hABCD, 1'b0);
        check_digits("hexABCD", 7'h08, 7'h03, 7'h46, 7'h21, 1'b0);
`endif

        // Reset in the middle of a conversion (or just after a hex load).
        wait_ready();
        in_value = 16'd49; in_overflow = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_an", {12'b0, an}, 16'h000F);
        chk("mrst_rdy", {15'b0, in_ready}, 16'h0001);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("mrst_rdy2", {15'b0, in_ready}, 16'h0001);
        check_digits("mrst", 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
